emulib_fifo_stream_reader: RTL and testbench

Read-side companion for `emulib_fifo`. It drains the FIFO's `rinc`/`rempty`/`rdata` port, whose data is registered with one cycle of latency, and presents the words as a valid/ready stream. It sustains one word per cycle with no combinational path from `m_ready` to `fifo_rinc`. It sits between any emulib FIFO and a stream consumer, such as a channel model or a host-side DMA sink.

---
 rtl/emulib_fifo_stream_reader_pkg.sv | 16 +
 rtl/emulib_fifo_stream_reader_if.sv | 22 ++
 rtl/emulib_fifo_reader_buf.sv | 58 +++++
 rtl/emulib_fifo_stream_reader.sv | 63 ++++++
 tb/tb_emulib_fifo_stream_reader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/emulib_fifo_stream_reader_pkg.sv
// Shared emulib stream-adapter constants: skid-queue depth, occupancy width and the read credit rule.
package emulib_fifo_stream_reader_pkg;

   localparam int unsigned BUF_DEPTH = 3;
   localparam int unsigned COUNT_W   = 2;

   typedef logic [COUNT_W-1:0] count_t;

   // A new read may issue only while buffered plus in-flight words leave a free slot.
   function automatic logic credit_ok(input count_t count, input logic inflight);
      logic [COUNT_W:0] used;
      used = {1'b0, count} + {{COUNT_W{1'b0}}, inflight};
      return used <= (COUNT_W+1)'(BUF_DEPTH - 1);
   endfunction

endpackage

// File: rtl/emulib_fifo_stream_reader_if.sv
// Valid/ready stream bundle produced by the emulib FIFO reader.
interface emulib_fifo_stream_reader_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );

endinterface

// File: rtl/emulib_fifo_reader_buf.sv
// Small register queue (BUF_DEPTH entries) with push/pop, occupancy and head outputs.
module emulib_fifo_reader_buf
   import emulib_fifo_stream_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output count_t           count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] mem_d [BUF_DEPTH];
   count_t           count_q;
   count_t           count_d;
   count_t           wr_idx;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = pop && (count_q != '0);
   assign push_ok = push && ((count_q != count_t'(BUF_DEPTH)) || pop_ok);

   // Entry 0 is always the head; a pop shifts everything down one slot before the push lands.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      wr_idx  = count_q;
      if (pop_ok) begin
         for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         wr_idx  = count_q - count_t'(1);
         count_d = count_q - count_t'(1);
      end
      if (push_ok) begin
         mem_d[wr_idx] = push_data;
         count_d       = count_d + count_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[0];

endmodule

// File: rtl/emulib_fifo_stream_reader.sv
// Drains an emulib FIFO read port (1-cycle data latency) into a valid/ready stream.
// Define EMULIB_FIFO_READER_BYPASS_EN to forward arriving data straight to an empty queue's output.
module emulib_fifo_stream_reader
   import emulib_fifo_stream_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   output logic                               fifo_rinc,
   input  logic                               fifo_rempty,
   input  logic [WIDTH-1:0]                   fifo_rdata,
   emulib_fifo_stream_reader_if.master        strm
);

   logic             inflight_q;
   logic             fire;
   logic             push;
   logic             pop;
   count_t           count;
   logic [WIDTH-1:0] head;

   // Credit depends on registered state only, so m_ready never reaches fifo_rinc.
   assign fifo_rinc = rst_n && !fifo_rempty && credit_ok(count, inflight_q);
   assign fire      = fifo_rinc && !fifo_rempty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= fire;
      end
   end

`ifdef EMULIB_FIFO_READER_BYPASS_EN
   logic bypass;

   assign bypass       = (count == '0) && inflight_q;
   assign strm.m_valid = (count != '0) || inflight_q;
   assign strm.m_data  = bypass ? fifo_rdata : head;
   assign pop          = (count != '0) && strm.m_ready;
   // A word consumed straight off the FIFO bus never enters the queue.
   assign push         = inflight_q && !(bypass && strm.m_ready);
`else
   assign strm.m_valid = (count != '0);
   assign strm.m_data  = head;
   assign pop          = strm.m_valid && strm.m_ready;
   assign push         = inflight_q;
`endif

   emulib_fifo_reader_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (fifo_rdata),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_emulib_fifo_stream_reader.sv
// Bench for emulib_fifo_stream_reader: FIFO model, scoreboard monitor, vector table and corner sequences.
module tb_emulib_fifo_stream_reader;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             fifo_rinc;
   logic             fifo_rempty = 1'b1;
   logic [WIDTH-1:0] fifo_rdata = '0;

   emulib_fifo_stream_reader_if #(.WIDTH(WIDTH)) strm ();

   emulib_fifo_stream_reader #(
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_rinc   (fifo_rinc),
      .fifo_rempty (fifo_rempty),
      .fifo_rdata  (fifo_rdata),
      .strm        (strm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             ready;
      logic             exp_rinc;
      logic             exp_valid;
      logic             chk_data;
      logic [WIDTH-1:0] exp_data;
   } vec_t;

   int               n_checks = 0;
   int               n_errors = 0;
   int               fire_total = 0;
   int               outstanding = 0;
   bit               fifo_clear = 1'b0;
   logic [WIDTH-1:0] fifo_q [$];
   logic [WIDTH-1:0] stage_q [$];
   logic [WIDTH-1:0] exp_q [$];
   vec_t             vecs [5];

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Word enters the FIFO on the next edge and is expected on the stream in order.
   task automatic load(input logic [WIDTH-1:0] w);
      stage_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Synchronous FIFO with registered read data held until the next accepted read.
   task automatic fifo_model();
      logic do_fire;
      forever begin
         @(negedge clk);
         do_fire = fifo_rinc && !fifo_rempty;
         @(posedge clk);
         if (fifo_clear) begin
            fifo_q.delete();
            stage_q.delete();
            fifo_rempty <= 1'b1;
         end else begin
            if (do_fire) fifo_rdata <= fifo_q.pop_front();
            while (stage_q.size() != 0) fifo_q.push_back(stage_q.pop_front());
            fifo_rempty <= (fifo_q.size() == 0);
         end
      end
   endtask

   task automatic monitor_loop();
      logic             prev_stall;
      logic [WIDTH-1:0] prev_data;
      logic             hs;
      logic             fire;
      logic [WIDTH-1:0] want;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
         end else begin
            hs   = strm.m_valid && strm.m_ready;
            fire = fifo_rinc && !fifo_rempty;
            check_bit("credit_bound", (outstanding <= 3), 1'b1);
            check_bit("rinc_while_empty", (fifo_rinc && fifo_rempty), 1'b0);
            if (prev_stall) begin
               check_bit("stall_valid", strm.m_valid, 1'b1);
               check("stall_data", strm.m_data, prev_data);
            end
            if (hs) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL sb_extra: got word %0h want none (t=%0t)", strm.m_data, $time);
               end else begin
                  want = exp_q.pop_front();
                  check("sb_data", strm.m_data, want);
               end
            end
            fire_total  += fire ? 1 : 0;
            outstanding += (fire ? 1 : 0) - (hs ? 1 : 0);
            prev_stall   = strm.m_valid && !strm.m_ready;
            prev_data    = strm.m_data;
         end
      end
   endtask

   initial begin
      int  f0;
      int  sent;
      int  n;
      bit  got;
      bit  empty_seen;

      strm.m_ready = 1'b0;
      fork
         monitor_loop();
         fifo_model();
         begin
            #1000000;
            $display("FAIL watchdog: time %0t exceeded limit", $time);
            $fatal(1, "watchdog");
         end
      join_none

`ifdef EMULIB_FIFO_READER_BYPASS_EN
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA1};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA2};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
`else
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA1};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hA2};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
`endif

      // Reset with the FIFO already holding two words.
      #1 rst_n = 1'b0;
      load(32'hA1);
      load(32'hA2);
      repeat (3) @(posedge clk);
      #1;
      check_bit("rst_rinc", fifo_rinc, 1'b0);
      check_bit("rst_valid", strm.m_valid, 1'b0);
      check("rst_data", strm.m_data, '0);
      strm.m_ready = 1'b1;
      tick();
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         strm.m_ready = vecs[k].ready;
         @(negedge clk);
         check_bit($sformatf("vec%0d_rinc", k), fifo_rinc, vecs[k].exp_rinc);
         check_bit($sformatf("vec%0d_valid", k), strm.m_valid, vecs[k].exp_valid);
         if (vecs[k].chk_data) check($sformatf("vec%0d_data", k), strm.m_data, vecs[k].exp_data);
      end

      // Sixteen words back to back with the consumer always ready.
      tick();
      for (int w = 0; w < 16; w++) load(WIDTH'(w));
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (strm.m_valid && strm.m_ready) got = 1'b1;
      end
      check_bit("stream_start", got, 1'b1);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         check_bit("stream_gap", strm.m_valid, 1'b1);
      end
      @(negedge clk);
      check_bit("stream_end_valid", strm.m_valid, 1'b0);

      // Backpressure: only three reads may be outstanding while stalled.
      tick();
      strm.m_ready = 1'b0;
      f0 = fire_total;
      for (int w = 0; w < 8; w++) load(WIDTH'(32'h30 + w));
      repeat (12) tick();
      check("bp_fire_count", WIDTH'(fire_total - f0), WIDTH'(3));
      check_bit("bp_rinc_low", fifo_rinc, 1'b0);
      check_bit("bp_valid_held", strm.m_valid, 1'b1);
      strm.m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_bit("bp_drain_gap", (strm.m_valid && strm.m_ready), 1'b1);
      end
      @(negedge clk);
      check_bit("bp_drain_end", strm.m_valid, 1'b0);

      // Random consumer readiness against random FIFO refills.
      sent = 0;
      got  = 1'b0;
      for (int c = 0; c < 20000 && !got; c++) begin
         tick();
         strm.m_ready = ($urandom() % 2) == 1;
         if (sent < 1000 && ($urandom() % 2) == 1) begin
            n = int'($urandom_range(1, 3));
            if (n > 1000 - sent) n = 1000 - sent;
            for (int j = 0; j < n; j++) load(WIDTH'($urandom()));
            sent += n;
         end
         if (sent == 1000 && exp_q.size() == 0) got = 1'b1;
      end
      check_bit("random_complete", got, 1'b1);

      // FIFO runs dry mid-stream; the last word must still come out.
      tick();
      strm.m_ready = 1'b1;
      for (int w = 0; w < 6; w++) load(WIDTH'(32'h50 + w));
      @(posedge clk);
      got        = 1'b0;
      empty_seen = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
         @(negedge clk);
         if (fifo_rempty && !empty_seen) begin
            empty_seen = 1'b1;
            check_bit("empty_rinc_drop", fifo_rinc, 1'b0);
         end
         if (strm.m_valid && strm.m_ready && strm.m_data == WIDTH'(32'h55)) got = 1'b1;
      end
      check_bit("last_word_55", got, 1'b1);
      @(negedge clk);
      check_bit("valid_drop_after_last", strm.m_valid, 1'b0);

      // Asynchronous reset with two words queued and one in flight.
      tick();
      strm.m_ready = 1'b0;
      f0 = fire_total;
      for (int w = 0; w < 8; w++) load(WIDTH'(32'h70 + w));
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         if (fire_total - f0 == 3) got = 1'b1;
      end
      check_bit("midrst_setup", got, 1'b1);
      check_bit("midrst_pre_valid", strm.m_valid, 1'b1);
      rst_n      = 1'b0;
      fifo_clear = 1'b1;
      exp_q.delete();
      #1;
      check_bit("midrst_rinc", fifo_rinc, 1'b0);
      check_bit("midrst_valid", strm.m_valid, 1'b0);
      check("midrst_data", strm.m_data, '0);
      repeat (2) tick();
      fifo_clear   = 1'b0;
      strm.m_ready = 1'b1;
      rst_n        = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_bit("no_stale_word", strm.m_valid, 1'b0);
      end
      tick();
      load(32'h81);
      load(32'h82);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         if (exp_q.size() == 0) got = 1'b1;
      end
      check_bit("post_reset_drain", got, 1'b1);

      repeat (5) tick();
      check("final_scoreboard_empty", WIDTH'(exp_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
